// File: rtl/sc130gs_cfg_pkg.sv
// sc130gs_cfg_pkg: shared types and constants for the SC130GS config sequencer
// Macro SC130GS_CFG_READBACK_EN adds the VERIFY_ISSUE/VERIFY_WAIT states.
package sc130gs_cfg_pkg;
   typedef enum logic [3:0] {
      IDLE, PWR_WAIT, FETCH, ISSUE, WAIT_RSP, GAP, RST_WAIT, DONE, ERROR
`ifdef SC130GS_CFG_READBACK_EN
      , VERIFY_ISSUE, VERIFY_WAIT
`endif
   } state_t;
   localparam logic [15:0] SOFT_RST_ADDR = 16'h0103;
   localparam logic [15:0] STREAM_ADDR   = 16'h0100;
   localparam int LUT_ADDR_HI = 23;
   localparam int LUT_ADDR_LO = 8;
   localparam int LUT_DATA_HI = 7;
   localparam int LUT_DATA_LO = 0;
endpackage

// File: rtl/sc130gs_wait_timer.sv
// sc130gs_wait_timer: loadable 24-bit down-counter for the sequencer waits
// Ports: clk, rst; i_load/i_val load a wait of i_val cycles (0 acts as 1);
// o_expired is high on the last cycle of the wait.
module sc130gs_wait_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic [23:0] i_val,
   output logic        o_expired
);
   logic [23:0] r_cnt;
   always_ff @(posedge clk) begin
      if (rst) r_cnt <= '0;
      else if (i_load) r_cnt <= (i_val == '0) ? '0 : i_val - 24'd1;
      else if (r_cnt != '0) r_cnt <= r_cnt - 24'd1;
   end
   assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/sc130gs_cfg_sequencer.sv
// sc130gs_cfg_sequencer: streams the register LUT into the SC130GS over I2C
// Ports: clk/rst; cfg_start in, cfg_busy/done/error status out; lut_index out,
// lut_data/lut_size in; cmd_* request to the I2C master with valid/ready;
// rsp_valid/nack/rdata completion from the master.
// Macro SC130GS_CFG_READBACK_EN: read back and compare each ordinary write.
module sc130gs_cfg_sequencer
   import sc130gs_cfg_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR     = 7'h30,
   parameter logic [23:0] PWR_WAIT_CYC = 24'd50_000,
   parameter logic [23:0] RST_WAIT_CYC = 24'd100_000,
   parameter logic [15:0] GAP_CYC      = 16'd100,
   parameter int          MAX_RETRY    = 3,
   parameter int          IDX_W        = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   output logic             cfg_busy,
   output logic             cfg_done,
   output logic             cfg_error,
   output logic [IDX_W-1:0] lut_index,
   input  logic [23:0]      lut_data,
   input  logic [IDX_W-1:0] lut_size,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [6:0]       cmd_dev,
   output logic [15:0]      cmd_addr,
   output logic [7:0]       cmd_wdata,
   output logic             cmd_rd,
   input  logic             rsp_valid,
   input  logic             rsp_nack,
   input  logic [7:0]       rsp_rdata
);
   state_t           r_state, w_next;
   logic [IDX_W-1:0] r_idx;
   logic [3:0]       r_retry;
   logic [15:0]      r_addr;
   logic [7:0]       r_wdata;
   logic             r_busy, r_done, r_error;
   logic             w_load, w_expired, w_retry_inc, w_retry_clr, w_idx_inc, w_start;
   logic             w_retry_max, w_last, w_in_rsp, w_fail;
   logic [23:0]      w_load_val;
   assign w_retry_max = (r_retry == 4'(MAX_RETRY));
   assign w_last      = (r_idx == lut_size - IDX_W'(1));
`ifdef SC130GS_CFG_READBACK_EN
   assign w_in_rsp = (r_state == WAIT_RSP) || (r_state == VERIFY_WAIT);
   assign w_fail   = rsp_nack || (r_state == VERIFY_WAIT && rsp_rdata != r_wdata);
   assign cmd_valid = (r_state == ISSUE) || (r_state == VERIFY_ISSUE);
   assign cmd_rd    = (r_state == VERIFY_ISSUE);
`else
   logic w_unused;
   assign w_unused  = ^rsp_rdata;
   assign w_in_rsp  = (r_state == WAIT_RSP);
   assign w_fail    = rsp_nack;
   assign cmd_valid = (r_state == ISSUE);
   assign cmd_rd    = 1'b0;
`endif
   sc130gs_wait_timer u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_val     (w_load_val),
      .o_expired (w_expired)
   );
   always_comb begin
      w_next      = r_state;
      w_load      = 1'b0;
      w_load_val  = '0;
      w_retry_inc = 1'b0;
      w_retry_clr = 1'b0;
      w_idx_inc   = 1'b0;
      w_start     = 1'b0;
      case (r_state)
         IDLE, DONE, ERROR: if (cfg_start) begin
            w_next     = PWR_WAIT;
            w_load     = 1'b1;
            w_load_val = PWR_WAIT_CYC;
            w_start    = 1'b1;
         end
         PWR_WAIT: if (w_expired) w_next = (lut_size == '0) ? DONE : FETCH;
         FETCH: w_next = ISSUE;
         ISSUE: if (cmd_ready) w_next = WAIT_RSP;
`ifdef SC130GS_CFG_READBACK_EN
         VERIFY_ISSUE: if (cmd_ready) w_next = VERIFY_WAIT;
`endif
         // a nonzero retry count in GAP means the entry is being re-issued
         GAP, RST_WAIT: if (w_expired) begin
            if (r_retry != '0) w_next = ISSUE;
            else if (w_last) w_next = DONE;
            else begin
               w_next    = FETCH;
               w_idx_inc = 1'b1;
            end
         end
         default: w_next = r_state;
      endcase
      if (w_in_rsp && rsp_valid) begin
         if (w_fail) begin
            w_next      = w_retry_max ? ERROR : GAP;
            w_load      = !w_retry_max;
            w_load_val  = {8'd0, GAP_CYC};
            w_retry_inc = !w_retry_max;
         end else if (r_addr == SOFT_RST_ADDR) begin
            w_next      = RST_WAIT;
            w_load      = 1'b1;
            w_load_val  = RST_WAIT_CYC;
            w_retry_clr = 1'b1;
`ifdef SC130GS_CFG_READBACK_EN
         // retries are kept across the write so a failing verify still terminates
         end else if (r_state == WAIT_RSP && r_addr != STREAM_ADDR) begin
            w_next = VERIFY_ISSUE;
`endif
         end else begin
            w_next      = GAP;
            w_load      = 1'b1;
            w_load_val  = {8'd0, GAP_CYC};
            w_retry_clr = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_retry <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= !(w_next inside {IDLE, DONE, ERROR});
         r_done  <= (w_next == DONE);
         r_error <= (w_next == ERROR);
         if (w_start) begin
            r_idx   <= '0;
            r_retry <= '0;
         end else begin
            if (w_idx_inc) r_idx <= r_idx + IDX_W'(1);
            if (w_retry_inc) r_retry <= r_retry + 4'd1;
            else if (w_retry_clr) r_retry <= '0;
         end
         if (r_state == FETCH) begin
            r_addr  <= lut_data[LUT_ADDR_HI:LUT_ADDR_LO];
            r_wdata <= lut_data[LUT_DATA_HI:LUT_DATA_LO];
         end
      end
   end
   assign cfg_busy  = r_busy;
   assign cfg_done  = r_done;
   assign cfg_error = r_error;
   assign lut_index = r_idx;
   assign cmd_dev   = DEV_ADDR;
   assign cmd_addr  = r_addr;
   assign cmd_wdata = r_wdata;
endmodule
